// File: rtl/hh_counter24_if.sv
// rtl/hh_counter24_if.sv - hour counter strobe/select inputs and BCD hour outputs
interface hh_counter24_if;
    logic       up_clock24;
    logic       up_alarm24;
    logic       clock_alarm;
    logic [1:0] clk_hh_tens;
    logic [3:0] clk_hh_units;
    logic [1:0] alm_hh_tens;
    logic [3:0] alm_hh_units;
    logic [1:0] disp_hh_tens;
    logic [3:0] disp_hh_units;
    logic       day_carry;
    logic       hh_match;

    modport master (
        output up_clock24, up_alarm24, clock_alarm,
        input  clk_hh_tens, clk_hh_units, alm_hh_tens, alm_hh_units,
        input  disp_hh_tens, disp_hh_units, day_carry, hh_match
    );

    modport slave (
        input  up_clock24, up_alarm24, clock_alarm,
        output clk_hh_tens, clk_hh_units, alm_hh_tens, alm_hh_units,
        output disp_hh_tens, disp_hh_units, day_carry, hh_match
    );
endinterface

// File: rtl/hh_counter24.sv
// rtl/hh_counter24.sv - clock and alarm BCD hour registers counting mod 24
module hh_counter24 #(
    parameter int RESET_CLOCK_HH = 0,
    parameter int RESET_ALARM_HH = 7
) (
    input  logic           ck,
    input  logic           reset,
    hh_counter24_if.slave  bus
);

    // Reset hours are only meaningful as legal 00..23 values.
    if (RESET_CLOCK_HH < 0 || RESET_CLOCK_HH > 23) begin : g_bad_clock_hh
        $error("hh_counter24: RESET_CLOCK_HH out of range 0..23");
    end
    if (RESET_ALARM_HH < 0 || RESET_ALARM_HH > 23) begin : g_bad_alarm_hh
        $error("hh_counter24: RESET_ALARM_HH out of range 0..23");
    end

    localparam logic [1:0] CLK_RST_TENS  = 2'(RESET_CLOCK_HH / 10);
    localparam logic [3:0] CLK_RST_UNITS = 4'(RESET_CLOCK_HH % 10);
    localparam logic [1:0] ALM_RST_TENS  = 2'(RESET_ALARM_HH / 10);
    localparam logic [3:0] ALM_RST_UNITS = 4'(RESET_ALARM_HH % 10);

    logic [1:0] clk_tens_q, alm_tens_q;
    logic [3:0] clk_units_q, alm_units_q;
    logic       day_carry_q;
    logic [5:0] clk_next, alm_next;
    logic       clk_at_23;

    // Next BCD hour after {tens, units}; anything illegal collapses to 00.
    function automatic logic [5:0] bcd_hh_inc(input logic [1:0] tens, input logic [3:0] units);
        logic [5:0] nxt;
        nxt = 6'd0;
        if (tens == 2'd2 && units == 4'd3) begin
            nxt = 6'd0;
        end else if (tens == 2'd2 && units < 4'd3) begin
            nxt = {tens, units + 4'd1};
        end else if (tens < 2'd2 && units < 4'd9) begin
            nxt = {tens, units + 4'd1};
        end else if (tens < 2'd2 && units == 4'd9) begin
            nxt = {tens + 2'd1, 4'd0};
        end else begin
            nxt = 6'd0;
        end
        return nxt;
    endfunction

    // Increment candidates and the 23 detect used for the day rollover.
    always_comb begin
        clk_next  = bcd_hh_inc(clk_tens_q, clk_units_q);
        alm_next  = bcd_hh_inc(alm_tens_q, alm_units_q);
        clk_at_23 = (clk_tens_q == 2'd2) && (clk_units_q == 4'd3);
    end

    // Clock hour register and the day-rollover pulse it produces.
    always_ff @(posedge ck or posedge reset) begin
        if (reset) begin
            clk_tens_q  <= CLK_RST_TENS;
            clk_units_q <= CLK_RST_UNITS;
            day_carry_q <= 1'b0;
        end else begin
            day_carry_q <= bus.up_clock24 && clk_at_23;
            if (bus.up_clock24) begin
                {clk_tens_q, clk_units_q} <= clk_next;
            end
        end
    end

    // Alarm hour register; its wrap never touches day_carry.
    always_ff @(posedge ck or posedge reset) begin
        if (reset) begin
            alm_tens_q  <= ALM_RST_TENS;
            alm_units_q <= ALM_RST_UNITS;
        end else if (bus.up_alarm24) begin
            {alm_tens_q, alm_units_q} <= alm_next;
        end
    end

    // Output digits, display select and the hour-match flag for the comparator.
    always_comb begin
        bus.clk_hh_tens   = clk_tens_q;
        bus.clk_hh_units  = clk_units_q;
        bus.alm_hh_tens   = alm_tens_q;
        bus.alm_hh_units  = alm_units_q;
        bus.disp_hh_tens  = bus.clock_alarm ? clk_tens_q  : alm_tens_q;
        bus.disp_hh_units = bus.clock_alarm ? clk_units_q : alm_units_q;
        bus.day_carry     = day_carry_q;
        bus.hh_match      = (clk_tens_q == alm_tens_q) && (clk_units_q == alm_units_q);
    end

endmodule

// File: tb/tb_hh_counter24.sv
// tb/tb_hh_counter24.sv - scoreboard bench for the BCD hour counter
module tb_hh_counter24;

    logic ck;
    logic reset;

    hh_counter24_if bus();

    hh_counter24 #(
        .RESET_CLOCK_HH(0),
        .RESET_ALARM_HH(7)
    ) dut (
        .ck    (ck),
        .reset (reset),
        .bus   (bus)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    typedef struct {
        logic       rst;
        logic       uc;
        logic       ua;
        logic       ca;
        int         clk_h;
        int         alm_h;
        logic       dc;
    } vec_t;

    typedef struct {
        logic [1:0] ct;
        logic [3:0] cu;
        logic [1:0] at;
        logic [3:0] au;
        logic       dc;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   seen  = 0;

    task automatic add(input logic rst, input logic uc, input logic ua, input logic ca,
                       input int clk_h, input int alm_h, input logic dc);
        vec_t v;
        v.rst = rst; v.uc = uc; v.ua = ua; v.ca = ca;
        v.clk_h = clk_h; v.alm_h = alm_h; v.dc = dc;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s entry=%0d actual=%0d required=%0d", name, seen, act, req);
        end
    endtask

    // Monitor: each falling edge with a pending expectation compares the outputs.
    initial begin
        exp_t e;
        logic [1:0] dt;
        logic [3:0] du;
        forever begin
            @(negedge ck);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                dt = bus.clock_alarm ? e.ct : e.at;
                du = bus.clock_alarm ? e.cu : e.au;
                check("clk_hh_tens",   int'(bus.clk_hh_tens),   int'(e.ct));
                check("clk_hh_units",  int'(bus.clk_hh_units),  int'(e.cu));
                check("alm_hh_tens",   int'(bus.alm_hh_tens),   int'(e.at));
                check("alm_hh_units",  int'(bus.alm_hh_units),  int'(e.au));
                check("day_carry",     int'(bus.day_carry),     int'(e.dc));
                check("hh_match",      int'(bus.hh_match),      int'((e.ct == e.at) && (e.cu == e.au)));
                check("disp_hh_tens",  int'(bus.disp_hh_tens),  int'(dt));
                check("disp_hh_units", int'(bus.disp_hh_units), int'(du));
                seen++;
            end
        end
    end

    // Stimulus: apply each vector and queue the hand-computed expected state.
    initial begin
        exp_t e;
        vec_t v;
        int   wait_cycles;
        reset = 1'b1;
        bus.up_clock24  = 1'b0;
        bus.up_alarm24  = 1'b0;
        bus.clock_alarm = 1'b1;

        // reset state, then display select alone in the same cycle
        add(1, 0, 0, 1, 0, 7, 0);
        add(1, 0, 0, 0, 0, 7, 0);
        add(0, 0, 0, 1, 0, 7, 0);
        // 24 single-cycle clock pulses: 01..23 then 00 with one day_carry
        for (int h = 1; h <= 23; h++) begin
            add(0, 1, 0, h[0], h, 7, 0);
            add(0, 0, 0, 1, h, 7, 0);
        end
        add(0, 1, 0, 1, 0, 7, 1);
        add(0, 0, 0, 1, 0, 7, 0);
        // alarm only: 08..14, then on to 23 and wrap to 00 with no day_carry
        for (int h = 8; h <= 23; h++) add(0, 0, 1, 0, 0, h, 0);
        add(0, 0, 1, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0);
        // alarm back to 07 (01..07)
        for (int h = 1; h <= 7; h++) add(0, 0, 1, 1, 0, h, 0);
        // clock held high up to 23
        for (int h = 1; h <= 23; h++) add(0, 1, 0, 1, h, 7, 0);
        // both strobes from clock 23 / alarm 07
        add(0, 1, 1, 1, 0, 8, 1);
        add(0, 0, 0, 1, 0, 8, 0);
        // clock up to alarm 08: match rises at 08, falls at 09
        for (int h = 1; h <= 9; h++) add(0, 1, 0, 1, h, 8, 0);
        add(0, 0, 0, 0, 9, 8, 0);
        for (int h = 10; h <= 20; h++) add(0, 1, 0, 1, h, 8, 0);
        // held 5 cycles from 20, then reset mid-burst with strobe still high
        add(0, 1, 0, 1, 21, 8, 0);
        add(0, 1, 0, 1, 22, 8, 0);
        add(0, 1, 0, 0, 23, 8, 0);
        add(0, 1, 0, 1, 0, 8, 1);
        add(0, 1, 0, 1, 1, 8, 0);
        add(1, 1, 0, 1, 0, 7, 0);
        add(0, 1, 0, 1, 1, 7, 0);
        add(0, 0, 0, 0, 1, 7, 0);

        foreach (vecs[i]) begin
            v = vecs[i];
            @(negedge ck);
            #1;
            if (v.rst) begin
                // assert reset between edges so the next sample proves it is asynchronous
                @(posedge ck);
                #1;
            end
            reset           = v.rst;
            bus.up_clock24  = v.uc;
            bus.up_alarm24  = v.ua;
            bus.clock_alarm = v.ca;
            e.ct = 2'(v.clk_h / 10);
            e.cu = 4'(v.clk_h % 10);
            e.at = 2'(v.alm_h / 10);
            e.au = 4'(v.alm_h % 10);
            e.dc = v.dc;
            sb.push_back(e);
        end

        wait_cycles = 0;
        while (sb.size() > 0 && wait_cycles < 10) begin
            @(negedge ck);
            wait_cycles++;
        end
        #1;
        total++;
        if (sb.size() != 0 || seen != vecs.size()) begin
            bad++;
            $display("FAIL scoreboard_drain actual=%0d required=%0d", seen, vecs.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
